csr_counter_bank: RTL and testbench

Parametrised machine/user counter bank that generalises the retired-instruction counter. It holds `mcycle`, `minstret` and `NUM_HPM` event counters (`mhpmcounter3..`), each with its own inhibit bit, and supports full-width software writes. It sits beside the CSR unit in the EXE stage. The pipeline supplies a one-bit retire strobe and raw event strobes. The CSR unit issues reads and writes and receives read data combinationally.

---
 rtl/csr_counter_bank.sv | 89 ++++++++
 tb/tb_csr_counter_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// Machine/user performance counter bank: mcycle, minstret and NUM_HPM event counters,
// each with an inhibit bit and full-width software writes.
module csr_counter_bank #(
  parameter int CNT_W   = 64,
  parameter int NUM_HPM = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 retire,
  input  logic [(NUM_HPM > 0 ? NUM_HPM : 1)-1:0] hpm_event,
  input  logic [11:0]                          csr_addr,
  input  logic                                 csr_rd,
  input  logic                                 csr_wr,
  input  logic [31:0]                          csr_wdata,
  output logic [31:0]                          csr_rdata,
  output logic                                 csr_hit,
  output logic                                 csr_illegal
);

  localparam int NC   = NUM_HPM + 3;
  localparam int HI_W = CNT_W - 32;

  logic             armed;
  logic [CNT_W-1:0] cnt [NC];
  logic [31:0]      inhibit;
  logic [31:0]      inh_mask;
  logic [NC-1:0]    ev;

  logic [4:0]       idx;
  logic             bank_b, bank_c, idx_ok, sel_cnt, sel_inh;
  logic             wr_m, wr_inh;
  logic [CNT_W-1:0] sel_val;
  logic [31:0]      cnt_half;

  // Index 1 has no event source and no legal address, so its counter stays at zero.
  always_comb begin
    ev       = '0;
    inh_mask = '0;
    ev[0]    = 1'b1;
    ev[2]    = retire;
    for (int n = 3; n < NC; n++) ev[n] = hpm_event[n-3];
    for (int n = 0; n < NC; n++) inh_mask[n] = (n != 1);
  end

  assign idx     = csr_addr[4:0];
  assign bank_b  = (csr_addr[11:8] == 4'hB);
  assign bank_c  = (csr_addr[11:8] == 4'hC);
  assign idx_ok  = (idx == 5'd0) || ((idx >= 5'd2) && (int'(idx) < NC));
  assign sel_cnt = (bank_b || bank_c) && (csr_addr[6:5] == 2'b00) && idx_ok;
  assign sel_inh = (csr_addr == 12'h320);

  assign csr_hit     = (csr_rd || csr_wr) && (sel_cnt || sel_inh);
  assign csr_illegal = csr_wr && sel_cnt && bank_c;
  assign wr_m        = csr_wr && sel_cnt && bank_b;
  assign wr_inh      = csr_wr && sel_inh;

  always_comb begin
    sel_val = '0;
    for (int n = 0; n < NC; n++)
      if (idx == 5'(n)) sel_val = cnt[n];
    cnt_half = csr_addr[7] ? 32'(sel_val >> 32) : sel_val[31:0];
  end

  always_comb begin
    csr_rdata = '0;
    if (csr_rd && csr_hit) csr_rdata = sel_inh ? inhibit : cnt_half;
  end

  // A software write to a counter wins over its increment in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed   <= 1'b0;
      inhibit <= '0;
      for (int n = 0; n < NC; n++) cnt[n] <= '0;
    end else begin
      armed <= 1'b1;
      if (wr_inh) inhibit <= csr_wdata & inh_mask;
      for (int n = 0; n < NC; n++) begin
        if (wr_m && (idx == 5'(n))) begin
          if (csr_addr[7]) cnt[n][CNT_W-1:32] <= csr_wdata[HI_W-1:0];
          else             cnt[n][31:0]       <= csr_wdata;
        end else if (armed && ev[n] && !inhibit[n]) begin
          cnt[n] <= cnt[n] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_csr_counter_bank.sv
// Self-checking bench for csr_counter_bank: a 64-bit and a 40-bit instance share stimulus.
module tb_csr_counter_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire;
  logic [1:0]  hpm_event;
  logic [11:0] csr_addr;
  logic        csr_rd, csr_wr;
  logic [31:0] csr_wdata;
  logic [31:0] rdata64, rdata40;
  logic        hit64, hit40, ill64, ill40;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        ret;
    logic [1:0]  hpm;
    int          steps;
    logic [31:0] exp_rd, exp_rd40;
    logic        exp_hit, exp_ill;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  always #50 clk = ~clk;

  csr_counter_bank #(.CNT_W(64), .NUM_HPM(2)) dut64 (
    .clk(clk), .rst(rst), .retire(retire), .hpm_event(hpm_event),
    .csr_addr(csr_addr), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_wdata(csr_wdata),
    .csr_rdata(rdata64), .csr_hit(hit64), .csr_illegal(ill64));

  csr_counter_bank #(.CNT_W(40), .NUM_HPM(2)) dut40 (
    .clk(clk), .rst(rst), .retire(retire), .hpm_event(hpm_event),
    .csr_addr(csr_addr), .csr_rd(csr_rd), .csr_wr(csr_wr), .csr_wdata(csr_wdata),
    .csr_rdata(rdata40), .csr_hit(hit40), .csr_illegal(ill40));

  function automatic vec_t mk(string name, logic rd, logic wr, logic [11:0] addr,
                              logic [31:0] wdata, logic ret, logic [1:0] hpm, int steps,
                              logic [31:0] exp_rd, logic exp_hit, logic exp_ill);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
    v.ret = ret; v.hpm = hpm; v.steps = steps;
    v.exp_rd = exp_rd; v.exp_rd40 = exp_rd; v.exp_hit = exp_hit; v.exp_ill = exp_ill;
    return v;
  endfunction

  function automatic void rdv(string name, logic [11:0] addr, logic [31:0] exp_rd, logic hit);
    vecs.push_back(mk(name, 1'b1, 1'b0, addr, 32'h0, 1'b0, 2'b00, 0, exp_rd, hit, 1'b0));
  endfunction

  function automatic void wrv(string name, logic [11:0] addr, logic [31:0] wdata, logic hit, logic ill);
    vecs.push_back(mk(name, 1'b0, 1'b1, addr, wdata, 1'b0, 2'b00, 1, 32'h0, hit, ill));
  endfunction

  function automatic void idl(string name, int steps, logic ret, logic [1:0] hpm);
    vecs.push_back(mk(name, 1'b0, 1'b0, 12'h000, 32'h0, ret, hpm, steps, 32'h0, 1'b0, 1'b0));
  endfunction

  task automatic set_idle();
    csr_rd = 1'b0; csr_wr = 1'b0; csr_addr = 12'h0; csr_wdata = 32'h0;
    retire = 1'b0; hpm_event = 2'b00;
  endtask

  task automatic check_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e = exp_q.pop_front();
    tests += 2;
    if (rdata64 !== e.exp_rd || hit64 !== e.exp_hit || ill64 !== e.exp_ill) begin
      fails++;
      $display("FAIL %s cnt64: got rdata=%h hit=%b ill=%b, expected rdata=%h hit=%b ill=%b",
               e.name, rdata64, hit64, ill64, e.exp_rd, e.exp_hit, e.exp_ill);
    end
    if (rdata40 !== e.exp_rd40 || hit40 !== e.exp_hit || ill40 !== e.exp_ill) begin
      fails++;
      $display("FAIL %s cnt40: got rdata=%h hit=%b ill=%b, expected rdata=%h hit=%b ill=%b",
               e.name, rdata40, hit40, ill40, e.exp_rd40, e.exp_hit, e.exp_ill);
    end
  endtask

  task automatic apply(input vec_t v);
    csr_rd = v.rd; csr_wr = v.wr; csr_addr = v.addr; csr_wdata = v.wdata;
    retire = v.ret; hpm_event = v.hpm;
    exp_q.push_back(v);
    #1 check_out();
    #1;
    repeat (v.steps) @(negedge clk);
    set_idle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    set_idle();

    // Main sequence; counter values noted as c (cycle), i (instret), h3/h4.
    idl("warmup_idle", 5, 1'b0, 2'b00);                 // c=4 (arming edge excluded)
    rdv("cycle_after_warmup", 12'hB00, 32'd4, 1'b1);
    rdv("user_instret_zero", 12'hC02, 32'd0, 1'b1);
    rdv("user_cycle_shadow", 12'hC00, 32'd4, 1'b1);
    idl("retire_burst", 10, 1'b1, 2'b00);               // c=14 i=10
    rdv("instret_lo_10", 12'hB02, 32'd10, 1'b1);
    rdv("instret_hi_0", 12'hB82, 32'd0, 1'b1);
    wrv("instret_clear", 12'hB02, 32'd0, 1'b1, 1'b0);  // c=15 i=0
    for (int k = 0; k < 10; k++) idl("retire_toggle", 1, (k % 2) == 0, 2'b00);
    rdv("instret_toggle_5", 12'hB02, 32'd5, 1'b1);     // c=25 i=5
    wrv("cycle_lo_ones", 12'hB00, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wrv("cycle_hi_ones", 12'hB80, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rdv("cycle_hi_written", 12'hB80, 32'hFFFF_FFFF, 1'b1);
    vecs[vecs.size()-1].exp_rd40 = 32'h0000_00FF;
    rdv("cycle_lo_written", 12'hB00, 32'hFFFF_FFFF, 1'b1);
    idl("wrap_step", 1, 1'b0, 2'b00);                   // c wraps to 0
    rdv("cycle_lo_wrapped", 12'hB00, 32'd0, 1'b1);
    rdv("cycle_hi_wrapped", 12'hB80, 32'd0, 1'b1);
    wrv("inhibit_set_5", 12'h320, 32'h5, 1'b1, 1'b0);  // c=1 (old inhibit still applies)
    idl("inhibited_run", 8, 1'b1, 2'b11);               // c=1 i=5 h3=h4=8
    rdv("cycle_frozen", 12'hB00, 32'd1, 1'b1);
    rdv("instret_frozen", 12'hB02, 32'd5, 1'b1);
    rdv("hpm3_advanced", 12'hB03, 32'd8, 1'b1);
    rdv("hpm4_advanced", 12'hB04, 32'd8, 1'b1);
    rdv("hpm4_user_hi", 12'hC84, 32'd0, 1'b1);
    rdv("inhibit_readback", 12'h320, 32'h5, 1'b1);
    rdv("hpm5_absent", 12'hB05, 32'd0, 1'b0);
    wrv("inhibit_all_ones", 12'h320, 32'hFFFF_FFFF, 1'b1, 1'b0);
    rdv("inhibit_mask", 12'h320, 32'h0000_001D, 1'b1);
    wrv("inhibit_clear", 12'h320, 32'h0, 1'b1, 1'b0); // c stays 1
    wrv("user_write_illegal", 12'hC00, 32'h1234, 1'b1, 1'b1); // c=2
    rdv("cycle_after_illegal", 12'hB00, 32'd2, 1'b1);
    rdv("index1_no_hit", 12'hB01, 32'd0, 1'b0);
    vecs.push_back(mk("index1_write_no_hit", 1'b0, 1'b1, 12'hB01, 32'h55, 1'b0, 2'b00, 0,
                      32'd0, 1'b0, 1'b0));
    vecs.push_back(mk("rd_wr_same_old", 1'b1, 1'b1, 12'hB00, 32'h77, 1'b0, 2'b00, 1,
                      32'd2, 1'b1, 1'b0));
    rdv("cycle_written_77", 12'hB00, 32'h77, 1'b1);
    idl("one_step", 1, 1'b0, 2'b00);
    rdv("cycle_78", 12'hB00, 32'h78, 1'b1);
    wrv("carry_lo_ones", 12'hB00, 32'hFFFF_FFFF, 1'b1, 1'b0);
    idl("carry_step", 1, 1'b0, 2'b00);
    rdv("carry_lo_0", 12'hB00, 32'd0, 1'b1);
    rdv("carry_hi_1", 12'hB80, 32'd1, 1'b1);
    vecs.push_back(mk("write_beats_retire", 1'b0, 1'b1, 12'hB02, 32'h100, 1'b1, 2'b01, 1,
                      32'd0, 1'b1, 1'b0));
    rdv("instret_exact_write", 12'hB02, 32'h100, 1'b1);
    rdv("hpm3_still_counts", 12'hB03, 32'd9, 1'b1);
    rdv("hpm4_unchanged", 12'hB04, 32'd8, 1'b1);

    // Reset-time outputs, then release and run the table.
    @(negedge clk);
    apply(mk("reset_idle", 1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 2'b00, 0, 32'd0, 1'b0, 1'b0));
    apply(mk("reset_read_cycle", 1'b1, 1'b0, 12'hB00, 32'h0, 1'b0, 2'b00, 0, 32'd0, 1'b1, 1'b0));
    rst = 1'b0;
    foreach (vecs[i]) apply(vecs[i]);

    // Reset pulse between clock edges: state clears at once, then warm-up repeats.
    @(negedge clk);
    apply(mk("pre_reset_running", 1'b1, 1'b0, 12'hB80, 32'h0, 1'b0, 2'b00, 0, 32'd1, 1'b1, 1'b0));
    #20 rst = 1'b1;
    #5;
    apply(mk("midreset_cycle_lo", 1'b1, 1'b0, 12'hB00, 32'h0, 1'b0, 2'b00, 0, 32'd0, 1'b1, 1'b0));
    apply(mk("midreset_cycle_hi", 1'b1, 1'b0, 12'hB80, 32'h0, 1'b0, 2'b00, 0, 32'd0, 1'b1, 1'b0));
    apply(mk("midreset_instret", 1'b1, 1'b0, 12'hB02, 32'h0, 1'b0, 2'b00, 0, 32'd0, 1'b1, 1'b0));
    #5 rst = 1'b0;
    @(negedge clk);
    apply(mk("rewarm_cycle_0", 1'b1, 1'b0, 12'hB00, 32'h0, 1'b0, 2'b00, 1, 32'd0, 1'b1, 1'b0));
    apply(mk("rewarm_cycle_1", 1'b1, 1'b0, 12'hB00, 32'h0, 1'b0, 2'b00, 0, 32'd1, 1'b1, 1'b0));

    if (exp_q.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
